// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and framing constants.
package uart_pkg;

  // Smallest usable clocks-per-bit; smaller divisor values are raised to this.
  localparam int DIV_MIN = 2;

  // Payload bits per frame (8N1), shared with the transmitter.
  localparam int DATA_BITS = 8;

  // Receiver state encoding, 3 bits wide.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } rx_state_e;

endpackage

// File: rtl/rx_uart_if.sv
// Ready/valid read port carrying received bytes out of the receiver FIFO.
interface rx_uart_if;
  import uart_pkg::*;

  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;

  // The receiver sources bytes; the consumer acknowledges with rx_ready.
  modport master (output rx_data, output rx_valid, input rx_ready);
  modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/uart_rx_fifo.sv
// Small receive FIFO with a registered head word that holds its value when empty.
module uart_rx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  pop,
  output logic                  full,
  output logic                  empty,
  output logic [DATA_WIDTH-1:0] dout
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]        count_q, count_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  push_ok, pop_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_FULL);
  assign pop_ok  = pop && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push_ok = push && (!full || pop_ok);
  assign dout    = dout_q;

  // Next head word and occupancy.
  always_comb begin
    dout_d  = dout_q;
    count_d = count_q;
    if (pop_ok) begin
      if (count_q > CNT_ONE) begin
        dout_d = mem_q[rd_ptr_q + PTR_ONE];
      end else if (push_ok) begin
        dout_d = din;
      end
    end else if (empty && push_ok) begin
      dout_d = din;
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Storage array, written without reset so it maps onto RAM.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  // Pointers, occupancy and head register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      count_q <= count_d;
      dout_q  <= dout_d;
    end
  end
endmodule

// File: rtl/rx_uart.sv
// 8N1 UART receiver: synchroniser, mid-bit sampling FSM and receive FIFO.
module rx_uart
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_in,
  input  logic [15:0] div,
  rx_uart_if.master   rx_port,
  output logic        frame_err,
  output logic        overrun,
  output logic        busy
);
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxs;
  logic [15:0]            div_eff;
  rx_state_e              state_q;
  logic [15:0]            cnt_q, deff_q;
  logic [IDX_W-1:0]       bit_idx_q;
  logic [DATA_BITS-1:0]   shift_q;
  logic                   frame_err_q, overrun_q;
  logic                   fifo_full, fifo_empty, fifo_pop, fifo_push;
  logic [DATA_BITS-1:0]   fifo_dout;

  assign rxs       = sync_q[SYNC_STAGES-1];
  assign div_eff   = (div < 16'(DIV_MIN)) ? 16'(DIV_MIN) : div;
  assign fifo_pop  = !fifo_empty && rx_port.rx_ready;
  // Push straight from the stop-sample cycle so the byte is visible next cycle.
  assign fifo_push = (state_q == S_STOP) && (cnt_q == '0) && rxs
                     && (!fifo_full || fifo_pop);

  assign rx_port.rx_valid = !fifo_empty;
  assign rx_port.rx_data  = fifo_dout;
  assign frame_err        = frame_err_q;
  assign overrun          = overrun_q;
  assign busy             = (state_q != S_IDLE);

  // Bring the asynchronous line into the clock domain; idles high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= '1;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], rx_in};
  end

  // Frame FSM: start validation, mid-bit data/stop sampling, error pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      deff_q      <= 16'(DIV_MIN);
      bit_idx_q   <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (!rxs) begin
            state_q <= S_START;
            deff_q  <= div_eff;
            cnt_q   <= (div_eff >> 1) - 16'd1;
          end
        end
        S_START: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 16'd1;
          end else if (!rxs) begin
            state_q   <= S_DATA;
            cnt_q     <= deff_q - 16'd1;
            bit_idx_q <= '0;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_DATA: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 16'd1;
          end else begin
            shift_q[bit_idx_q] <= rxs;
            cnt_q              <= deff_q - 16'd1;
            if (bit_idx_q == IDX_LAST) state_q <= S_STOP;
            else                       bit_idx_q <= bit_idx_q + IDX_ONE;
          end
        end
        S_STOP: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 16'd1;
          end else if (rxs) begin
            if (!fifo_push) overrun_q <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            frame_err_q <= 1'b1;
            state_q     <= S_BREAK;
          end
        end
        S_BREAK: begin
          if (rxs) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  uart_rx_fifo #(
    .DATA_WIDTH (DATA_BITS),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (reset),
    .push  (fifo_push),
    .din   (shift_q),
    .pop   (fifo_pop),
    .full  (fifo_full),
    .empty (fifo_empty),
    .dout  (fifo_dout)
  );
endmodule
